// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences weight load, pixel feed and result write-back for one window+conv pass
module conv_seq_ctrl #(
  parameter int KSIZE   = 5,
  parameter int IMG_L   = 28,
  parameter int IMG_S   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  output logic       w_rd,
  output logic [4:0] w_addr,
  output logic       conv_w_en,
  output logic       conv_start,
  output logic       conv_state,
  output logic       win_start,
  output logic       pix_rd,
  output logic [9:0] pix_addr,
  input  logic       conv_ovalid,
  input  logic       conv_done,
  output logic       res_we,
  output logic [9:0] res_addr,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int NW  = KSIZE * KSIZE;
  localparam int NPL = IMG_L * IMG_L;
  localparam int NPS = IMG_S * IMG_S;
  localparam int NOL = (IMG_L - KSIZE + 1) * (IMG_L - KSIZE + 1);
  localparam int NOS = (IMG_S - KSIZE + 1) * (IMG_S - KSIZE + 1);
  typedef enum logic [2:0] {IDLE, WLOAD, WSYNC, FEED, DRAIN, FIN} state_t;
  state_t state, state_nx;
  logic [9:0] cnt, wcnt, tcnt, wcnt_nx, npix, nout;
  logic accept, wr_phase, has_room, wlast, plast, timeout, overflow, feed_done, drain_bad;
  // image geometry follows the mode captured at start, so mid-pass mode changes are inert
  assign npix      = conv_state ? 10'(NPS) : 10'(NPL);
  assign nout      = conv_state ? 10'(NOS) : 10'(NOL);
  assign accept    = state == IDLE && start;
  assign wr_phase  = state == FEED || state == DRAIN;
  assign has_room  = wcnt < nout;
  assign res_we    = wr_phase && conv_ovalid && has_room;
  assign wcnt_nx   = wcnt + 10'(res_we);
  assign wlast     = state == WLOAD && cnt == 10'(NW - 1);
  assign plast     = state == FEED && cnt == npix - 10'd1;
  assign timeout   = state == DRAIN && !conv_ovalid && tcnt == 10'(TIMEOUT - 1);
  assign overflow  = wr_phase && conv_ovalid && !has_room;
  assign feed_done = state == FEED && conv_done;
  assign drain_bad = state == DRAIN && conv_done && wcnt_nx != nout;
  assign busy       = state != IDLE;
  assign w_rd       = state == WLOAD;
  assign w_addr     = w_rd ? cnt[4:0] : 5'd0;
  assign pix_rd     = state == FEED;
  assign pix_addr   = pix_rd ? cnt : 10'd0;
  assign conv_start = state inside {WLOAD, WSYNC, FEED, DRAIN};
  assign win_start  = wr_phase;
  assign done       = state == FIN && !abort;
  assign res_addr   = wcnt;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? WLOAD : IDLE;
      WLOAD:   state_nx = wlast ? WSYNC : WLOAD;
      WSYNC:   state_nx = FEED;
      FEED:    state_nx = conv_done ? FIN : plast ? DRAIN : FEED;
      DRAIN:   state_nx = (conv_done || timeout) ? FIN : DRAIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wcnt       <= '0;
      tcnt       <= '0;
      conv_state <= 1'b0;
      conv_w_en  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state     <= state_nx;
      conv_w_en <= w_rd && !abort;
      if (accept) begin
        conv_state <= mode;
        err        <= 1'b0;
        cnt        <= '0;
        wcnt       <= '0;
        tcnt       <= '0;
      end else begin
        wcnt <= wcnt_nx;
        cnt  <= wlast ? '0 : (w_rd || pix_rd) && cnt != '1 ? cnt + 10'd1 : cnt;
        tcnt <= state != DRAIN || conv_ovalid ? '0 : tcnt != '1 ? tcnt + 10'd1 : tcnt;
        if (!abort && (overflow || feed_done || drain_bad || timeout)) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: randomized scoreboard bench with a behavioural conv stand-in
module tb_conv_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, mode = 1'b0, abort = 1'b0, conv_ovalid = 1'b0, conv_done = 1'b0;
  logic w_rd, conv_w_en, conv_start, conv_state, win_start, pix_rd, res_we, busy, done, err;
  logic [4:0] w_addr;
  logic [9:0] pix_addr, res_addr;
  int compared = 0, mismatched = 0;
  int wq[$], pq[$], rq[$], fq[$];
  bit eq[$];
  bit sb_en = 1'b1, exp_mode = 1'b0, prev_wen = 1'b0, prev_done = 1'b0;

  conv_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .w_rd(w_rd), .w_addr(w_addr), .conv_w_en(conv_w_en), .conv_start(conv_start),
    .conv_state(conv_state), .win_start(win_start), .pix_rd(pix_rd), .pix_addr(pix_addr),
    .conv_ovalid(conv_ovalid), .conv_done(conv_done), .res_we(res_we), .res_addr(res_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every DUT output event is matched against the queued expectation
  always @(negedge clk) begin
    if (rst) begin
      prev_wen  <= 1'b0;
      prev_done <= 1'b0;
    end else begin
      chk("conv_w_en", conv_w_en, prev_wen);
      prev_wen  <= w_rd && !abort;
      prev_done <= done;
      if (done) chk("busy_with_done", busy, 1);
      if (prev_done) chk("busy_after_done", busy, 0);
      if (sb_en) begin
        if (w_rd) begin
          if (wq.size() == 0) chk("w_rd_unexpected", 1, 0);
          else chk("w_addr", w_addr, wq.pop_front());
        end
        if (pix_rd) begin
          if (pq.size() == 0) chk("pix_rd_unexpected", 1, 0);
          else chk("pix_addr", pix_addr, pq.pop_front());
        end
        if (res_we) begin
          if (rq.size() == 0) chk("res_we_unexpected", 1, 0);
          else chk("res_addr", res_addr, rq.pop_front());
        end
        if (done) begin
          if (eq.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            chk("err_at_done", err, eq.pop_front());
            chk("res_addr_final", res_addr, fq.pop_front());
          end
        end
        if (busy) chk("conv_state", conv_state, exp_mode);
      end
    end
  end

  // fd >= 0: single result carrying conv_done issued at FEED pixel fd
  task automatic run_pass(input bit m, input int nemit, input int didx, input bit poke,
                          input int fd, input bit ab);
    int npix = m ? 144 : 784;
    int nout = m ? 64 : 576;
    int nw = nemit < nout ? nemit : nout;
    int sent = 0, fc = 0;
    bit ok = 0;
    for (int i = 0; i < 25; i++) wq.push_back(i);
    for (int i = 0; i < (fd >= 0 ? fd + 1 : npix); i++) pq.push_back(i);
    for (int i = 0; i < nw; i++) rq.push_back(i);
    eq.push_back(didx == 0 || didx != nout || fd >= 0);
    fq.push_back(nw);
    exp_mode = m;
    mode = m; start = 1'b1; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; mode = 1'($urandom_range(0, 1));
    chk("err_cleared_on_start", err, 0);
    chk("busy_on_start", busy, 1);
    for (int c = 0; c < 5000; c++) begin
      conv_ovalid = 1'b0; conv_done = 1'b0; start = 1'b0;
      if (!busy) begin
        ok = 1;
        break;
      end
      if (poke && pix_rd && fc == 200) begin
        start = 1'b1; mode = ~m;
      end
      if (fd >= 0) begin
        if (pix_rd && fc == fd) begin
          conv_ovalid = 1'b1; conv_done = 1'b1;
        end
      end else if (win_start && sent < nemit) begin
        bit last, go;
        last = didx != 0 && sent + 1 == didx;
        go = pix_rd ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        if (last && pix_rd) go = 0;
        if (go) begin
          conv_ovalid = 1'b1; conv_done = last; sent++;
        end
      end
      if (pix_rd) fc++;
      @(posedge clk); #1;
    end
    conv_ovalid = 1'b0; conv_done = 1'b0; start = 1'b0;
    if (!ok) chk("pass_timeout", 1, 0);
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs_a", {w_rd, w_addr, conv_w_en, conv_start, conv_state, win_start, pix_rd}, 0);
    chk("reset_outputs_b", {pix_addr, res_we, res_addr, busy, done, err}, 0);
    @(posedge clk); #1;
    run_pass(0, 576, 576, 0, -1, 0);
    run_pass(1, 64, 64, 0, -1, 0);
    run_pass(0, 576, 576, 1, -1, 0);
    run_pass(0, 100, 100, 0, -1, 0);
    chk("res_addr_stop_100", res_addr, 100);
    run_pass(0, 50, 0, 0, -1, 0);
    chk("err_sticky_after_timeout", err, 1);
    run_pass(1, 64, 64, 0, -1, 0);
    run_pass(1, 1, 1, 0, 30, 0);
    chk("err_after_feed_done", err, 1);
    // asynchronous reset in the middle of FEED
    sb_en = 1'b0;
    mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 400; c++) begin
      if (pix_rd && pix_addr == 10'd100) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reached_feed_100", hit, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", {w_rd, w_addr, conv_w_en, conv_start, conv_state, win_start, pix_rd}, 0);
    chk("async_rst_b", {pix_addr, res_we, res_addr, busy, done, err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    sb_en = 1'b1;
    // abort during WLOAD weight 10
    for (int i = 0; i <= 10; i++) wq.push_back(i);
    exp_mode = 1'b0; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("abort_at_w10", w_addr, 10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {busy, w_rd, conv_w_en, conv_start, win_start, pix_rd, done}, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    run_pass(0, 576, 576, 0, -1, 1);
    for (int k = 0; k < 3; k++) begin
      bit m;
      m = 1'($urandom_range(0, 1));
      run_pass(m, m ? 64 : 576, m ? 64 : 576, 0, -1, 0);
    end
    repeat (2) @(posedge clk);
    chk("wq_left", wq.size(), 0);
    chk("pq_left", pq.size(), 0);
    chk("rq_left", rq.size(), 0);
    chk("done_left", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
